// File: rtl/div_arbiter.sv
// div_arbiter: two-port arbiter and start/latency sequencer for the shared iterative divider.
// Build option: define DIV_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module div_arbiter #(
  parameter int WIDTH        = 32,
  parameter int START_CYCLES = 1,
  parameter int LATENCY      = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dz,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);
  // state | meaning
  // IDLE  | waiting for a request; winner's operands latched on exit
  // LOAD  | div_start held high while the divider loads operands
  // RUN   | waiting out the divider's fixed latency
  // DONE  | one-cycle completion pulse to the granted port
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int MAX_CYC = (START_CYCLES > LATENCY) ? START_CYCLES : LATENCY;
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             gnt, gnt_nxt;
  logic             any_req, pick;
  logic [WIDTH-1:0] a_win, b_win;
  logic [WIDTH-1:0] a_nxt, b_nxt, q_nxt, r_nxt;
  logic             dz_nxt;

  assign any_req = req0 | req1;

`ifdef DIV_ARB_RR_EN
  logic last;

  // On a tie the port that was not granted last wins.
  assign pick = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last <= pick;
    end
  end
`else
  assign pick = ~req0;
`endif

  assign a_win = pick ? a1 : a0;
  assign b_win = pick ? b1 : b0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    a_nxt     = div_a;
    b_nxt     = div_b;
    q_nxt     = q_out;
    r_nxt     = r_out;
    dz_nxt    = dz;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nxt = pick;
          a_nxt   = a_win;
          b_nxt   = b_win;
          cnt_nxt = '0;
          if (b_win == '0) begin
            // Divide by zero is answered directly; the divider is never started.
            state_nxt = DONE;
            q_nxt     = '1;
            r_nxt     = a_win;
            dz_nxt    = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (cnt == START_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (cnt == RUN_LAST) begin
          state_nxt = DONE;
          q_nxt     = div_q;
          r_nxt     = div_r;
          dz_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      q_out     <= '0;
      r_out     <= '0;
      dz        <= 1'b0;
      div_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      div_a     <= a_nxt;
      div_b     <= b_nxt;
      q_out     <= q_nxt;
      r_out     <= r_nxt;
      dz        <= dz_nxt;
      div_start <= (state_nxt == LOAD);
    end
  end

  assign busy  = (state != IDLE);
  assign done0 = (state == DONE) & ~gnt;
  assign done1 = (state == DONE) & gnt;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized and directed bench for div_arbiter against a per-transaction reference model.
// Tie-breaking expectations follow DIV_ARB_RR_EN exactly as the design build does.
module tb_div_arbiter;
  localparam int W    = 32;
  localparam int S    = 1;
  localparam int L    = 33;
  localparam int NCYC = 1 + S + L;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [W-1:0] div_q, div_r;
  logic         done0, done1, dz, busy, div_start;
  logic [W-1:0] q_out, r_out, div_a, div_b;

  int errors = 0;
  int checks = 0;
  bit rand_en = 1'b0;
  bit drop0 = 1'b1, drop1 = 1'b1;

  div_arbiter #(.WIDTH(W), .START_CYCLES(S), .LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .q_out(q_out), .r_out(r_out), .dz(dz), .busy(busy),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Divider stand-in: result only becomes valid LATENCY cycles after start falls.
  logic [W-1:0] dv_a = '0, dv_b = '0, dv_qt, dv_rt;
  int           dv_cnt = 1000;
  always @(posedge clock) begin
    if (div_start) begin
      dv_a   <= div_a;
      dv_b   <= div_b;
      dv_cnt <= 0;
    end else if (dv_cnt < 1000) begin
      dv_cnt <= dv_cnt + 1;
    end
  end
  always_comb begin
    dv_qt = (dv_b == '0) ? '1 : dv_a / dv_b;
    dv_rt = (dv_b == '0) ? dv_a : dv_a % dv_b;
    div_q = (dv_cnt >= L - 1) ? dv_qt : dv_qt ^ 32'h5A5A_5A5A;
    div_r = (dv_cnt >= L - 1) ? dv_rt : dv_rt ^ 32'hA5A5_A5A5;
  end

  function automatic int winner(input logic r0, input logic r1, input logic last);
`ifdef DIV_ARB_RR_EN
    if (r0 && r1) return last ? 0 : 1;
`endif
    return r0 ? 0 : 1;
  endfunction

  // Reference model: one transaction at a time, m_cd counts cycles left until the end of DONE.
  int           m_cd = 0, m_port = 0, w_now;
  logic         m_last = 1'b1;
  logic [W-1:0] m_a = '0, m_b = '0, wa, wb;
  always_comb begin
    w_now = winner(req0, req1, m_last);
    wa    = (w_now == 1) ? a1 : a0;
    wb    = (w_now == 1) ? b1 : b0;
  end
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cd   <= 0;
      m_last <= 1'b1;
    end else if (m_cd != 0) begin
      m_cd <= m_cd - 1;
    end else if (req0 || req1) begin
      m_port <= w_now;
      m_last <= (w_now == 1);
      m_a    <= wa;
      m_b    <= wb;
      m_cd   <= (wb == '0) ? 1 : NCYC;
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset) begin
      check("done0", done0, m_cd == 1 && m_port == 0);
      check("done1", done1, m_cd == 1 && m_port == 1);
      check("busy", busy, m_cd != 0);
      check("div_start", div_start, m_cd > 1 + L);
      if (m_cd != 0) begin
        check("div_a", div_a, m_a);
        check("div_b", div_b, m_b);
      end
      if (m_cd == 1) begin
        check("q_out", q_out, (m_b == '0) ? {W{1'b1}} : m_a / m_b);
        check("r_out", r_out, (m_b == '0) ? m_a : m_a % m_b);
        check("dz", dz, m_b == '0);
      end
    end
  end

  function automatic logic [W-1:0] rand_b();
    int k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k == 1) return $urandom;
    return W'($urandom_range(1, 300));
  endfunction

  initial forever begin
    @(negedge clock);
    if (done0 && drop0) req0 = 1'b0;
    else if (rand_en && !req0 && $urandom_range(0, 3) == 0) begin
      a0 = $urandom; b0 = rand_b(); req0 = 1'b1;
    end
  end

  initial forever begin
    @(negedge clock);
    if (done1 && drop1) req1 = 1'b0;
    else if (rand_en && !req1 && $urandom_range(0, 3) == 0) begin
      a1 = $urandom; b1 = rand_b(); req1 = 1'b1;
    end
  end

  task automatic run_until_done(input int port, input bit mutate, output int cyc, output int starts);
    bit seen = 1'b0;
    cyc = 0;
    starts = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      cyc++;
      if (div_start) starts++;
      if (mutate && cyc == 10) a0 = 50;
      if ((port == 0 && done0) || (port == 1 && done1)) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (!busy && !req0 && !req1) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       cyc, st, n;
    logic [2:0] ord, ord_exp;

    #1;
    check("rst_busy", busy, 0);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_dz", dz, 0);
    check("rst_start", div_start, 0);
    check("rst_q", q_out, 0);
    check("rst_r", r_out, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single divide, with port 0 operand disturbed in the middle of RUN.
    a0 = 7; b0 = 3; req0 = 1'b1;
    run_until_done(0, 1'b1, cyc, st);
    check("single_cycle", cyc, NCYC);
    check("single_q", q_out, 2);
    check("single_r", r_out, 1);
    check("single_dz", dz, 0);
    check("single_starts", st, 1);
    wait_idle();

    // Divide by zero on port 1.
    a1 = 5; b1 = 0; req1 = 1'b1;
    run_until_done(1, 1'b0, cyc, st);
    check("dz_cycle", cyc, 1);
    check("dz_q", q_out, 32'hFFFF_FFFF);
    check("dz_r", r_out, 5);
    check("dz_flag", dz, 1);
    check("dz_starts", st, 0);
    wait_idle();

    // Tie with port 0 re-requesting continuously.
    a0 = 100; b0 = 7; a1 = 9; b1 = 4;
    drop0 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    ord = '0;
    for (int c = 0; c < 300 && n < 3; c++) begin
      @(negedge clock);
      if (done0 || done1) begin
        ord[n] = done1;
        check("tie_q", q_out, done1 ? 2 : 14);
        check("tie_r", r_out, done1 ? 1 : 2);
        n++;
      end
    end
    req0 = 1'b0;
    drop0 = 1'b1;
`ifdef DIV_ARB_RR_EN
    ord_exp = 3'b010;
`else
    ord_exp = 3'b000;
`endif
    check("tie_count", n, 3);
    check("tie_order", ord, ord_exp);
    wait_idle();

    // Reset in the middle of RUN.
    a0 = 7; b0 = 3; req0 = 1'b1;
    repeat (10) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done0", done0, 0);
    check("mid_rst_done1", done1, 0);
    check("mid_rst_start", div_start, 0);
    check("mid_rst_dz", dz, 0);
    check("mid_rst_q", q_out, 0);
    check("mid_rst_r", r_out, 0);
    check("mid_rst_div_a", div_a, 0);
    check("mid_rst_div_b", div_b, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    a0 = 100; b0 = 7; req0 = 1'b1;
    run_until_done(0, 1'b0, cyc, st);
    check("post_rst_cycle", cyc, NCYC);
    check("post_rst_q", q_out, 14);
    check("post_rst_r", r_out, 2);
    wait_idle();

    // Randomized traffic from both ports.
    rand_en = 1'b1;
    repeat (4000) @(negedge clock);
    rand_en = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Controller and two-port arbiter for the shared iterative `Division` unit. It accepts divide requests from two independent requesters and grants the divider to one of them at a time. It sequences the divider's `start` load/run protocol, counts the fixed iteration latency and captures `q`/`r`. It returns the result to the granted requester with a one-cycle completion pulse. It sits between the execution stage(s) and the single `Division` instance.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.
- `START_CYCLES`, default 1: cycles `div_start` is held high to load operands.
- `LATENCY`, default 33: cycles after `div_start` falls until `div_q`/`div_r` are valid.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req0`, `req1`, input, 1 each: request; held high until the matching `done` pulse.
- `a0`, `b0`, `a1`, `b1`, input, WIDTH each: dividend and divisor per requester; stable while `req` is high.
- `done0`, `done1`, output, 1 each: one-cycle completion pulse for the matching requester.
- `q_out`, `r_out`, output, WIDTH each: shared quotient and remainder registers; valid when a `done` is high; held until the next completion.
- `dz`, output, 1: divide-by-zero flag; qualified by `done`.
- `busy`, output, 1: high whenever the state is not IDLE.
- `div_start`, output, 1: drives `Division.start`.
- `div_a`, `div_b`, output, WIDTH each: drive `Division.a` and `Division.b`.
- `div_q`, `div_r`, input, WIDTH each: from `Division.q` and `Division.r`.

## Operation
States: IDLE, LOAD, RUN, DONE.

- **IDLE:**
  - If any `req` is high, select a winner (see Configuration).
  - Latch the winner's `a` and `b` into `div_a` and `div_b`.
  - Latch the winner's index into `gnt`.
  - If the latched `b` is 0, go to DONE with `q_out` = all ones, `r_out` = `a`, `dz` = 1. The divider is not started.
  - Otherwise go to LOAD.
- **LOAD:**
  - `div_start` = 1.
  - Counter runs 0..START_CYCLES-1, then go to RUN with the counter cleared.
- **RUN:**
  - `div_start` = 0.
  - Counter runs 0..LATENCY-1.
  - On the final count: capture `div_q` into `q_out`, `div_r` into `r_out`, clear `dz`, and go to DONE.
- **DONE:**
  - `done[gnt]` = 1 for exactly one cycle.
  - Go to IDLE unconditionally.
- **Handshake:**
  - A requester drops `req` in the cycle after it sees `done`.
  - If `req` is still high in IDLE, it is treated as a new request.
  - A non-granted requester keeps `req` high and waits; it is never dropped.
- **Operand isolation:** `div_a` and `div_b` stay constant from IDLE exit until the next grant. Changes on `a0`/`b0`/`a1`/`b1` during LOAD or RUN have no effect.
- **Counter width:** `$clog2(max(START_CYCLES, LATENCY)) + 1` bits.
- **Reset values (any time, asynchronous):**
  - State IDLE.
  - `div_start`, `done0`, `done1`, `dz`, `busy` = 0.
  - `q_out`, `r_out`, `div_a`, `div_b` = 0.
  - Round-robin pointer prefers port 0.
  - Reset during LOAD or RUN aborts the operation and produces no `done` pulse.

## Timing
- A request is sampled on the IDLE rising edge (edge 0).
- Normal divide: `done` is high in cycle 1+START_CYCLES+LATENCY after edge 0, which is 35 cycles with defaults. `q_out`/`r_out` update on the same edge that raises `done`.
- Divide by zero: `done` is high in cycle 1.
- Back-to-back: the next grant can occur on the edge that ends DONE+1, giving one idle cycle between operations.
- `div_start` is registered and glitch-free.

## Configuration
- **`DIV_ARB_RR_EN` defined:** round-robin arbitration.
  - On a tie, the port not granted last wins.
  - The pointer updates on every grant, including divide-by-zero grants.
- **`DIV_ARB_RR_EN` undefined:** fixed priority. `req0` always beats `req1`, and no pointer register exists.

## Test plan
- **Single divide:** `req0` with a0=7, b0=3, `req1` low. Required: `done0` high in cycle 35, `q_out`=2, `r_out`=1, `dz`=0, and `div_start` high for exactly 1 cycle.
- **Simultaneous requests, macro defined:** `req0` (100/7) and `req1` (9/4) rise together. Required sequence:
  - `done0` first, with q=14, r=2.
  - Then `done1`, with q=2, r=1.
  - Next tie goes to port 1 first.
- **Simultaneous requests, macro undefined:** same stimulus as above. Required: port 0 wins every tie. Continuous `req0` traffic starves `req1`.
- **Divide by zero:** `req1` with a1=5, b1=0. Required:
  - `done1` in cycle 1.
  - `q_out`=FFFFFFFF, `r_out`=5, `dz`=1.
  - `div_start` never asserted.
- **Reset mid-operation:** `reset` low during RUN at cycle 10. Required:
  - All outputs immediately at reset values.
  - No `done` pulse.
  - A new request afterwards completes with correct results.
- **Operand change during RUN:** change a0 to 50 during RUN. Required: the result still reflects the latched operands, 7/3 → 2 r1.
